// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one I-cache request at a time and holds
// {pc, inst} for the IFU->IDU register, dropping responses made stale by a redirect.
module ifu_fetch_ctrl #(
   parameter int              PC_W   = 32,
   parameter int              INST_W = 32,
   parameter logic [PC_W-1:0] PC_RST = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              stall,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [PC_W-1:0]   req_addr,
   input  logic              rsp_valid,
   input  logic [INST_W-1:0] rsp_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       kill_cnt
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [PC_W-1:0]     pc_req_q;
   logic                kill_q, kill_d;
   logic [PC_W-1:0]     out_pc_q;
   logic [INST_W-1:0]   out_inst_q;
   logic [31:0]         fetch_cnt_q, kill_cnt_q;

   logic                req_hs;
   logic                rsp_take;
   logic                rsp_drop;
   logic                rsp_keep;
   logic                deliver;
   logic                req_enter;
   logic [PC_W-1:0]     redirect_tgt;

   assign redirect_tgt = {redirect_pc[PC_W-1:2], 2'b00};
   assign req_hs       = (state_q == REQ) && req_ready;
   assign rsp_take     = (state_q == WAIT) && rsp_valid;
   assign rsp_drop     = rsp_take && (kill_q || redirect_valid);
   assign rsp_keep     = rsp_take && !rsp_drop;
   // A redirect outranks delivery: the held instruction is wrong-path.
   assign deliver      = (state_q == HOLD) && out_ready && !stall && !redirect_valid;
   assign req_enter    = (state_d == REQ) && (state_q != REQ);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ:  if (req_hs) state_d = WAIT;
         WAIT: begin
            if (rsp_drop)      state_d = REQ;
            else if (rsp_keep) state_d = HOLD;
         end
         HOLD: if (redirect_valid || deliver) state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_valid = (state_q == REQ);
      out_valid = (state_q == HOLD);
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid)
         pc_d = redirect_tgt;
      else if (deliver)
         pc_d = pc_q + PC_W'(4);
   end

   // An address already presented (or accepted) cannot be retracted, so its response is marked stale.
   always_comb begin
      kill_d = kill_q;
      if (rsp_drop)
         kill_d = 1'b0;
      else if (redirect_valid && ((state_q == REQ) || (state_q == WAIT)))
         kill_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= PC_RST;
         pc_req_q    <= PC_RST;
         kill_q      <= 1'b0;
         out_pc_q    <= '0;
         out_inst_q  <= '0;
         fetch_cnt_q <= '0;
         kill_cnt_q  <= '0;
      end else begin
         pc_q   <= pc_d;
         kill_q <= kill_d;
         if (req_enter)
            pc_req_q <= pc_d;
         if (rsp_keep) begin
            out_pc_q   <= pc_req_q;
            out_inst_q <= rsp_inst;
         end
         if (deliver)
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (rsp_drop)
            kill_cnt_q <= kill_cnt_q + 32'd1;
      end
   end

   assign req_addr  = pc_req_q;
   assign out_pc    = out_pc_q;
   assign out_inst  = out_inst_q;
   assign fetch_cnt = fetch_cnt_q;
   assign kill_cnt  = kill_cnt_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: a directed cycle table, then randomized traffic against a
// transaction-level model of the architectural PC, stale responses and perf counters.
module tb_ifu_fetch_ctrl;

   localparam logic [31:0] A = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [31:0] fetch_cnt;
   logic [31:0] kill_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   ifu_fetch_ctrl #(.PC_W(32), .INST_W(32), .PC_RST(A)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_inst(rsp_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .fetch_cnt(fetch_cnt), .kill_cnt(kill_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, rdv;
      logic [31:0] rdpc;
      logic        stall, rrdy, rspv;
      logic [31:0] rspi;
      logic        ordy;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_ov;
      logic [31:0] e_opc, e_oi, e_fc, e_kc;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic rdv, input logic [31:0] rdpc,
                               input logic st, input logic rrdy, input logic rspv,
                               input logic [31:0] rspi, input logic ordy,
                               input logic e_rv, input logic [31:0] e_addr, input logic e_ov,
                               input logic [31:0] e_opc, input logic [31:0] e_oi,
                               input logic [31:0] e_fc, input logic [31:0] e_kc);
      vec_t v;
      v.rst = r; v.rdv = rdv; v.rdpc = rdpc; v.stall = st; v.rrdy = rrdy; v.rspv = rspv;
      v.rspi = rspi; v.ordy = ordy; v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov;
      v.e_opc = e_opc; v.e_oi = e_oi; v.e_fc = e_fc; v.e_kc = e_kc;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] addr);
      return {addr[15:0], addr[31:16]} ^ 32'h5A5A_1234;
   endfunction

   task automatic do_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_inst = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic run_table();
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         rst = vecs[i].rst; redirect_valid = vecs[i].rdv; redirect_pc = vecs[i].rdpc;
         stall = vecs[i].stall; req_ready = vecs[i].rrdy; rsp_valid = vecs[i].rspv;
         rsp_inst = vecs[i].rspi; out_ready = vecs[i].ordy;
         @(negedge clk);
         check($sformatf("tbl%0d_req_valid", i), 32'(req_valid), 32'(vecs[i].e_rv));
         check($sformatf("tbl%0d_req_addr", i),  req_addr,  vecs[i].e_addr);
         check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
         check($sformatf("tbl%0d_out_pc", i),    out_pc,    vecs[i].e_opc);
         check($sformatf("tbl%0d_out_inst", i),  out_inst,  vecs[i].e_oi);
         check($sformatf("tbl%0d_fetch_cnt", i), fetch_cnt, vecs[i].e_fc);
         check($sformatf("tbl%0d_kill_cnt", i),  kill_cnt,  vecs[i].e_kc);
      end
   endtask

   // Model: every delivered instruction belongs to the current architectural PC; a response
   // is stale if any redirect arrived while its request was presented or outstanding.
   task automatic run_random(input int n);
      logic [31:0] exp_pc, req_pc, cache_addr;
      bit          in_req, tainted, busy, dlv;
      int          delay, chk;
      int unsigned m_fetch, m_kill;
      exp_pc = A; req_pc = A; cache_addr = '0;
      in_req = 0; tainted = 0; busy = 0; delay = 0; chk = 0; m_fetch = 0; m_kill = 0;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         rst = 1'b0;
         case (chk)
            1: begin
               check("rnd_ov_after_rsp", 32'(out_valid), 32'd1);
               check("rnd_out_pc", out_pc, exp_pc);
               check("rnd_out_inst", out_inst, inst_of(exp_pc));
            end
            3: begin
               check("rnd_ov_hold", 32'(out_valid), 32'd1);
               check("rnd_out_pc_hold", out_pc, exp_pc);
            end
            default: check("rnd_ov_idle", 32'(out_valid), 32'd0);
         endcase
         chk = 0;
         check("rnd_fetch_cnt", fetch_cnt, m_fetch);
         check("rnd_kill_cnt", kill_cnt, m_kill);

         redirect_valid = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 7) == 0)
            redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         else
            redirect_pc = A | ($urandom & 32'hFFFF);
         stall     = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         req_ready = ($urandom_range(0, 2) != 0);
         rsp_valid = 1'b0;
         rsp_inst  = $urandom;
         if (busy) begin
            if (delay == 0) begin
               rsp_valid = 1'b1;
               rsp_inst  = inst_of(cache_addr);
            end else begin
               delay--;
            end
         end else if ($urandom_range(0, 9) == 0) begin
            rsp_valid = 1'b1;
         end

         @(negedge clk);
         if (req_valid) begin
            if (!in_req) begin
               check("rnd_req_addr", req_addr, exp_pc);
               in_req = 1; req_pc = exp_pc; tainted = 0;
            end else begin
               check("rnd_req_stable", req_addr, req_pc);
            end
         end
         if (redirect_valid && (req_valid || busy)) tainted = 1;
         if (busy && rsp_valid) begin
            busy = 0;
            if (tainted) begin
               m_kill++;
               chk = 2;
            end else begin
               chk = 1;
            end
         end
         if (req_valid && req_ready) begin
            busy = 1; cache_addr = req_pc; delay = $urandom_range(0, 2); in_req = 0;
         end
         dlv = out_valid && out_ready && !stall && !redirect_valid;
         if (out_valid) begin
            if (dlv) begin
               check("rnd_deliver_pc", out_pc, exp_pc);
               m_fetch++;
               exp_pc = exp_pc + 32'd4;
               chk = 2;
            end else if (redirect_valid) begin
               chk = 2;
            end else begin
               chk = 3;
            end
         end
         if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      end
   endtask

   initial begin
      // rst rdv rdpc      st rr rv rspi  or | rv addr     ov opc      oi  fc kc
      add(0, 0, 0,         0, 1, 0, 0,    1,   0, A,       0, 0,       0,  0, 0);
      add(0, 0, 0,         0, 1, 0, 0,    1,   1, A,       0, 0,       0,  0, 0);
      add(0, 0, 0,         0, 1, 1, 'h11, 1,   0, A,       0, 0,       0,  0, 0);
      add(0, 0, 0,         0, 1, 0, 0,    1,   0, A,       1, A,       'h11, 0, 0);
      add(0, 0, 0,         0, 1, 0, 0,    1,   1, A+4,     0, A,       'h11, 1, 0);
      add(0, 0, 0,         0, 1, 1, 'h22, 1,   0, A+4,     0, A,       'h11, 1, 0);
      add(0, 0, 0,         1, 1, 0, 0,    1,   0, A+4,     1, A+4,     'h22, 1, 0);
      add(0, 0, 0,         0, 1, 0, 0,    0,   0, A+4,     1, A+4,     'h22, 1, 0);
      add(0, 0, 0,         1, 1, 0, 0,    1,   0, A+4,     1, A+4,     'h22, 1, 0);
      add(0, 0, 0,         1, 1, 0, 0,    1,   0, A+4,     1, A+4,     'h22, 1, 0);
      add(0, 0, 0,         1, 1, 0, 0,    1,   0, A+4,     1, A+4,     'h22, 1, 0);
      add(0, 0, 0,         0, 1, 0, 0,    1,   0, A+4,     1, A+4,     'h22, 1, 0);
      add(0, 0, 0,         0, 1, 0, 0,    1,   1, A+8,     0, A+4,     'h22, 2, 0);
      add(0, 1, A+'h102,   0, 1, 0, 0,    1,   0, A+8,     0, A+4,     'h22, 2, 0);
      add(0, 0, 0,         0, 1, 1, 'h33, 1,   0, A+8,     0, A+4,     'h22, 2, 0);
      add(0, 0, 0,         0, 0, 0, 0,    1,   1, A+'h100, 0, A+4,     'h22, 2, 1);
      add(0, 1, A+'h200,   0, 0, 0, 0,    1,   1, A+'h100, 0, A+4,     'h22, 2, 1);
      add(0, 0, 0,         0, 0, 0, 0,    1,   1, A+'h100, 0, A+4,     'h22, 2, 1);
      add(0, 0, 0,         0, 1, 0, 0,    1,   1, A+'h100, 0, A+4,     'h22, 2, 1);
      add(0, 0, 0,         0, 1, 1, 'h44, 1,   0, A+'h100, 0, A+4,     'h22, 2, 1);
      add(0, 0, 0,         0, 1, 0, 0,    1,   1, A+'h200, 0, A+4,     'h22, 2, 2);
      add(0, 1, A+'h300,   0, 1, 1, 'h55, 1,   0, A+'h200, 0, A+4,     'h22, 2, 2);
      add(0, 0, 0,         0, 1, 0, 0,    1,   1, A+'h300, 0, A+4,     'h22, 2, 3);
      add(0, 0, 0,         0, 1, 1, 'h66, 1,   0, A+'h300, 0, A+4,     'h22, 2, 3);
      add(0, 1, A+'h400,   0, 1, 0, 0,    1,   0, A+'h300, 1, A+'h300, 'h66, 2, 3);
      add(0, 0, 0,         0, 1, 0, 0,    1,   1, A+'h400, 0, A+'h300, 'h66, 2, 3);
      add(0, 0, 0,         0, 1, 0, 0,    1,   0, A+'h400, 0, A+'h300, 'h66, 2, 3);
      add(1, 0, 0,         0, 1, 0, 0,    1,   0, A+'h400, 0, A+'h300, 'h66, 2, 3);
      add(0, 0, 0,         0, 1, 1, 'h77, 1,   0, A,       0, 0,       0,  0, 0);
      add(0, 0, 0,         0, 0, 0, 0,    1,   1, A,       0, 0,       0,  0, 0);
      add(0, 0, 0,         0, 1, 0, 0,    1,   1, A,       0, 0,       0,  0, 0);
      add(0, 0, 0,         0, 1, 1, 'h88, 1,   0, A,       0, 0,       0,  0, 0);
      add(0, 0, 0,         0, 1, 0, 0,    0,   0, A,       1, A,       'h88, 0, 0);

      do_reset();
      run_table();
      do_reset();
      run_random(3000);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
